cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among NUM_FU functional-unit result ports (ALU, MUL, DIV, LSU by default).
- The CDB carries the same result to the ROB, the reservation stations and the RAT/ARF ready-bit logic.
- Each FU gets a one-entry holding buffer, so a unit can complete while it waits for the bus.
- A round-robin grant picks one buffered result per cycle and drives a registered CDB broadcast. A flush (mispredict/exception) drops all pending results.

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cdb_arbiter.sv | 147 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: FU result packet layout,
// FU slot indices and bit offsets of the packed result fields.
package cdb_arbiter_pkg;

   localparam int ROB_IDX_W = 5;

   // Packed layout, MSB first: {rob_idx, rd_addr, data, regf_we}
   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [4:0]           rd_addr;
      logic [31:0]          data;
      logic                 regf_we;
   } fu_result_t;

   localparam int FU_ALU = 0;
   localparam int FU_MUL = 1;
   localparam int FU_DIV = 2;
   localparam int FU_LSU = 3;

   // Field offsets inside one packed result, independent of rob width
   localparam int FU_WE_LSB   = 0;
   localparam int FU_DATA_LSB = 1;
   localparam int FU_RD_LSB   = 33;
   localparam int FU_ROB_LSB  = 38;

   function automatic int fu_result_w(input int rob_w);
      return rob_w + FU_ROB_LSB;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req upward from ptr,
// wrapping, and returns a one-hot (or zero) grant.
// Ports: req (requests), ptr (start index), grant (one-hot winner).
module rr_arbiter #(
   parameter int NUM_FU = 4,
   parameter int PTR_W  = 2
) (
   input  logic [NUM_FU-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_FU-1:0] grant
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (int'(ptr) + k) % NUM_FU;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per FU, round-robin
// grant, registered CDB broadcast, flush squash, conflict counter.
// Ports: clk, rst (sync, active-high), flush, fu_valid/fu_result
// (flat NUM_FU x packed fu_result_t), fu_ready (comb accept),
// cdb_* registered broadcast, cdb_grant (one-hot source),
// perf_conflicts (saturating count of cycles with >=2 buffers valid).
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU        = 4,
   parameter int ROB_IDX_WIDTH = ROB_IDX_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [NUM_FU-1:0]               fu_valid,
   input  logic [NUM_FU*(ROB_IDX_WIDTH+38)-1:0] fu_result,
   output logic [NUM_FU-1:0]               fu_ready,
   output logic                            cdb_valid,
   output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx,
   output logic [4:0]                      cdb_rd_addr,
   output logic [31:0]                     cdb_data,
   output logic                            cdb_regf_we,
   output logic [NUM_FU-1:0]               cdb_grant,
   output logic [31:0]                     perf_conflicts
);

   localparam int RES_W = fu_result_w(ROB_IDX_WIDTH);
   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [ROB_IDX_WIDTH-1:0] in_rob   [NUM_FU];
   logic [4:0]               in_rd    [NUM_FU];
   logic [31:0]              in_data  [NUM_FU];
   logic [NUM_FU-1:0]        in_we;

   logic [ROB_IDX_WIDTH-1:0] buf_rob  [NUM_FU];
   logic [4:0]               buf_rd   [NUM_FU];
   logic [31:0]              buf_data [NUM_FU];
   logic [NUM_FU-1:0]        buf_we;
   logic [NUM_FU-1:0]        buf_valid;

   logic [NUM_FU-1:0]        grant;
   logic [NUM_FU-1:0]        load;
   logic                     any_grant;
   logic                     conflict;

   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         rr_next;
   logic [PTR_W-1:0]         win_idx;
   logic [ROB_IDX_WIDTH-1:0] win_rob;
   logic [4:0]               win_rd;
   logic [31:0]              win_data;
   logic                     win_we;

   for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
      assign in_we[g]   = fu_result[g*RES_W + FU_WE_LSB];
      assign in_data[g] = fu_result[g*RES_W + FU_DATA_LSB +: 32];
      assign in_rd[g]   = fu_result[g*RES_W + FU_RD_LSB +: 5];
      assign in_rob[g]  = fu_result[g*RES_W + FU_ROB_LSB +: ROB_IDX_WIDTH];
   end

   rr_arbiter #(
      .NUM_FU (NUM_FU),
      .PTR_W  (PTR_W)
   ) u_rr (
      .req   (buf_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // A granted buffer drains this edge, so it can accept a refill
   assign fu_ready  = ~buf_valid | grant;
   assign load      = fu_valid & fu_ready;
   assign any_grant = |grant;
   assign conflict  = $countones(buf_valid) >= 2;

   always_comb begin
      win_idx  = '0;
      win_rob  = '0;
      win_rd   = '0;
      win_data = '0;
      win_we   = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            win_idx  = PTR_W'(i);
            win_rob  = buf_rob[i];
            win_rd   = buf_rd[i];
            win_data = buf_data[i];
            win_we   = buf_we[i];
         end
      end
   end

   always_comb begin
      rr_next = win_idx + 1'b1;
      if (int'(win_idx) == NUM_FU - 1) begin
         rr_next = '0;
      end
   end

   // Payload storage needs no reset; buf_valid qualifies it
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (load[i] && !flush && !rst) begin
            buf_rob[i]  <= in_rob[i];
            buf_rd[i]   <= in_rd[i];
            buf_data[i] <= in_data[i];
            buf_we[i]   <= in_we[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid      <= '0;
         rr_ptr         <= '0;
         cdb_valid      <= 1'b0;
         cdb_rob_idx    <= '0;
         cdb_rd_addr    <= '0;
         cdb_data       <= '0;
         cdb_regf_we    <= 1'b0;
         cdb_grant      <= '0;
         perf_conflicts <= '0;
      end else if (flush) begin
         buf_valid <= '0;
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_grant <= '0;
      end else begin
         buf_valid <= load | (buf_valid & ~grant);
         cdb_valid <= any_grant;
         cdb_grant <= grant;
         if (any_grant) begin
            rr_ptr      <= rr_next;
            cdb_rob_idx <= win_rob;
            cdb_rd_addr <= win_rd;
            cdb_data    <= win_data;
            // x0 is hardwired, never advertise a write to it
            cdb_regf_we <= win_we && (win_rd != 5'd0);
         end
         if (conflict && (perf_conflicts != 32'hFFFF_FFFF)) begin
            perf_conflicts <= perf_conflicts + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors
// plus hand sequences for single FU, x0, fairness, flush, reset.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int RES_W = $bits(fu_result_t);

   logic             clk;
   logic             rst;
   logic             flush;
   logic [N-1:0]     fu_valid;
   logic [N*RES_W-1:0] fu_result;
   logic [N-1:0]     fu_ready;
   logic             cdb_valid;
   logic [4:0]       cdb_rob_idx;
   logic [4:0]       cdb_rd_addr;
   logic [31:0]      cdb_data;
   logic             cdb_regf_we;
   logic [N-1:0]     cdb_grant;
   logic [31:0]      perf_conflicts;

   int total = 0;
   int bad   = 0;

   cdb_arbiter #(
      .NUM_FU        (N),
      .ROB_IDX_WIDTH (5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .fu_valid       (fu_valid),
      .fu_result      (fu_result),
      .fu_ready       (fu_ready),
      .cdb_valid      (cdb_valid),
      .cdb_rob_idx    (cdb_rob_idx),
      .cdb_rd_addr    (cdb_rd_addr),
      .cdb_data       (cdb_data),
      .cdb_regf_we    (cdb_regf_we),
      .cdb_grant      (cdb_grant),
      .perf_conflicts (perf_conflicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic        fl;
      logic [3:0]  fv;
      logic [3:0]  e_ready;
      logic        e_valid;
      logic [3:0]  e_grant;
      logic [31:0] e_perf;
   } vec_t;

   vec_t tbl [17];
   logic [3:0] g_log [12];
   logic       v_log [12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic fu_result_t cpkt(input int i);
      fu_result_t p;
      p.rob_idx = 5'(i + 10);
      p.rd_addr = 5'(i + 1);
      p.data    = 32'hA0A0_0000 | 32'(i);
      p.regf_we = 1'b1;
      return p;
   endfunction

   task automatic set_pkt(input int i, input fu_result_t p);
      fu_result[i*RES_W +: RES_W] = p;
   endtask

   task automatic const_pkts();
      for (int i = 0; i < N; i++) set_pkt(i, cpkt(i));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      flush    = 1'b0;
      fu_valid = '0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, " valid"}, 64'(cdb_valid), 64'd0);
      chk({nm, " grant"}, 64'(cdb_grant), 64'd0);
      chk({nm, " rob"},   64'(cdb_rob_idx), 64'd0);
      chk({nm, " rd"},    64'(cdb_rd_addr), 64'd0);
      chk({nm, " data"},  64'(cdb_data), 64'd0);
      chk({nm, " we"},    64'(cdb_regf_we), 64'd0);
      chk({nm, " perf"},  64'(perf_conflicts), 64'd0);
      chk({nm, " ready"}, 64'(fu_ready), 64'hF);
   endtask

   initial begin
      fu_result_t p;
      int fu2c;
      int viol;
      int vcnt;
      fu_result = '0;
      rst       = 1'b1;
      flush     = 1'b0;
      fu_valid  = '0;
      next_cycle();
      do_reset();

      // Reset state, then single FU1 packet
      @(negedge clk);
      chk_reset_outs("rst0");
      next_cycle();
      p = '{rob_idx: 5'd3, rd_addr: 5'd5, data: 32'hDEADBEEF, regf_we: 1'b1};
      set_pkt(1, p);
      for (int c = 0; c < 5; c++) begin
         fu_valid = (c == 0) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         chk($sformatf("single c%0d valid", c), 64'(cdb_valid),
             64'(c == 2));
         if (c == 2) begin
            chk("single grant", 64'(cdb_grant), 64'b0010);
            chk("single rob",   64'(cdb_rob_idx), 64'd3);
            chk("single rd",    64'(cdb_rd_addr), 64'd5);
            chk("single data",  64'(cdb_data), 64'hDEADBEEF);
            chk("single we",    64'(cdb_regf_we), 64'd1);
         end
         next_cycle();
      end

      // Table: all-four burst, refill stream, two-way contention
      tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 32'd0};
      tbl[1]  = '{1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 32'd0};
      tbl[2]  = '{1'b0, 4'b0000, 4'b0011, 1'b1, 4'b0001, 32'd1};
      tbl[3]  = '{1'b0, 4'b0000, 4'b0111, 1'b1, 4'b0010, 32'd2};
      tbl[4]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0100, 32'd3};
      tbl[5]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1000, 32'd3};
      tbl[6]  = '{1'b0, 4'b0100, 4'b1111, 1'b0, 4'b0000, 32'd3};
      tbl[7]  = '{1'b0, 4'b0100, 4'b1111, 1'b0, 4'b0000, 32'd3};
      tbl[8]  = '{1'b0, 4'b0100, 4'b1111, 1'b1, 4'b0100, 32'd3};
      tbl[9]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0100, 32'd3};
      tbl[10] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0100, 32'd3};
      tbl[11] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 32'd3};
      tbl[12] = '{1'b0, 4'b0011, 4'b1111, 1'b0, 4'b0000, 32'd3};
      tbl[13] = '{1'b0, 4'b0000, 4'b1101, 1'b0, 4'b0000, 32'd3};
      tbl[14] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0001, 32'd4};
      tbl[15] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0010, 32'd4};
      tbl[16] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 32'd4};

      do_reset();
      const_pkts();
      for (int r = 0; r < 17; r++) begin
         flush    = tbl[r].fl;
         fu_valid = tbl[r].fv;
         @(negedge clk);
         chk($sformatf("row%0d ready", r), 64'(fu_ready),
             64'(tbl[r].e_ready));
         chk($sformatf("row%0d valid", r), 64'(cdb_valid),
             64'(tbl[r].e_valid));
         chk($sformatf("row%0d grant", r), 64'(cdb_grant),
             64'(tbl[r].e_grant));
         chk($sformatf("row%0d perf", r), 64'(perf_conflicts),
             64'(tbl[r].e_perf));
         if (tbl[r].e_valid) begin
            for (int j = 0; j < N; j++) begin
               if (tbl[r].e_grant[j]) begin
                  p = cpkt(j);
                  chk($sformatf("row%0d rob", r), 64'(cdb_rob_idx),
                      64'(p.rob_idx));
                  chk($sformatf("row%0d rd", r), 64'(cdb_rd_addr),
                      64'(p.rd_addr));
                  chk($sformatf("row%0d data", r), 64'(cdb_data),
                      64'(p.data));
                  chk($sformatf("row%0d we", r), 64'(cdb_regf_we),
                      64'd1);
               end
            end
         end
         next_cycle();
      end
      flush    = 1'b0;
      fu_valid = '0;

      // Write to x0 must not assert regf_we on the bus
      do_reset();
      p = '{rob_idx: 5'd7, rd_addr: 5'd0, data: 32'h1234, regf_we: 1'b1};
      set_pkt(3, p);
      for (int c = 0; c < 3; c++) begin
         fu_valid = (c == 0) ? 4'b1000 : 4'b0000;
         @(negedge clk);
         if (c == 2) begin
            chk("x0 valid", 64'(cdb_valid), 64'd1);
            chk("x0 grant", 64'(cdb_grant), 64'b1000);
            chk("x0 we",    64'(cdb_regf_we), 64'd0);
            chk("x0 data",  64'(cdb_data), 64'h1234);
         end
         next_cycle();
      end

      // Fairness: FU0 streams, FU2 sends once at c1
      do_reset();
      const_pkts();
      for (int c = 0; c < 11; c++) begin
         fu_valid    = '0;
         fu_valid[0] = (c < 8);
         fu_valid[2] = (c == 1);
         @(negedge clk);
         g_log[c] = cdb_grant;
         v_log[c] = cdb_valid;
         if (c == 1) chk("fair fu2 ready", 64'(fu_ready[2]), 64'd1);
         if (c == 2) chk("fair fu0 stall", 64'(fu_ready[0]), 64'd0);
         next_cycle();
      end
      fu_valid = '0;
      fu2c = -1;
      for (int c = 0; c < 11; c++) begin
         if (fu2c < 0 && g_log[c] == 4'b0100) fu2c = c;
      end
      chk("fair fu2 cycle", 64'(fu2c), 64'd3);
      viol = 0;
      for (int c = 3; c < 11; c++) begin
         if (c <= fu2c && g_log[c] == 4'b0001 && g_log[c-1] == 4'b0001)
            viol++;
      end
      chk("fair fu0 b2b", 64'(viol), 64'd0);
      vcnt = 0;
      for (int c = 0; c < 11; c++) vcnt += int'(v_log[c]);
      chk("fair valid cnt", 64'(vcnt), 64'd8);
      chk("fair c4 grant", 64'(g_log[4]), 64'b0001);
      chk("fair c10 valid", 64'(v_log[10]), 64'd0);

      // Flush with three buffers full, FU3 handshake in flush cycle
      do_reset();
      const_pkts();
      vcnt = 0;
      for (int c = 0; c < 10; c++) begin
         flush    = (c == 1);
         fu_valid = (c == 0) ? 4'b0111 :
                    (c == 1) ? 4'b1000 :
                    (c == 6) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (c == 1) chk("flush ready", 64'(fu_ready), 64'b1001);
         if (c == 2) begin
            chk("flush valid", 64'(cdb_valid), 64'd0);
            chk("flush grant", 64'(cdb_grant), 64'd0);
            chk("flush ready2", 64'(fu_ready), 64'hF);
            chk("flush perf", 64'(perf_conflicts), 64'd0);
         end
         if (c >= 2 && c <= 7) vcnt += int'(cdb_valid);
         if (c == 8) chk("flush rr0", 64'(cdb_grant), 64'b0001);
         if (c == 9) chk("flush rr1", 64'(cdb_grant), 64'b0010);
         next_cycle();
      end
      flush    = 1'b0;
      fu_valid = '0;
      chk("flush quiet", 64'(vcnt), 64'd0);

      // Reset mid-traffic overrides inputs and restores rr_ptr
      do_reset();
      const_pkts();
      for (int c = 0; c < 10; c++) begin
         rst      = (c == 2);
         flush    = (c == 2);
         fu_valid = (c == 0 || c == 2 || c == 4) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (c == 2) begin
            chk("rst pre valid", 64'(cdb_valid), 64'd1);
            chk("rst pre perf", 64'(perf_conflicts), 64'd1);
         end
         if (c == 3) chk_reset_outs("rst mid");
         if (c >= 6) chk($sformatf("rst order c%0d", c), 64'(cdb_grant),
                         64'(4'b0001 << (c - 6)));
         next_cycle();
      end
      rst      = 1'b0;
      flush    = 1'b0;
      fu_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
